// File: rtl/writeback_queue.sv
// writeback_queue: in-order result buffer feeding the register file write port.
// Optional forwarding lookup of pending results enabled by macro WB_FORWARD_EN.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   inValid/inReady         producer handshake; inReg/inData carry the result
//   drainEn                 register file write port available this cycle
//   regWrite/writeReg/Data  register file write port (head entry)
//   queryReg                forwarding lookup index
//   queryHit/queryData      youngest pending value for queryReg
//   count                   occupancy 0..DEPTH
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       inValid,
    output logic                       inReady,
    input  logic [ADDR_W-1:0]          inReg,
    input  logic [DATA_W-1:0]          inData,
    input  logic                       drainEn,
    output logic                       regWrite,
    output logic [ADDR_W-1:0]          writeReg,
    output logic [DATA_W-1:0]          writeData,
    input  logic [ADDR_W-1:0]          queryReg,
    output logic                       queryHit,
    output logic [DATA_W-1:0]          queryData,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] regMem  [DEPTH];
    logic [DATA_W-1:0] dataMem [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [CNT_W-1:0]  cnt;

    logic notEmpty;
    logic enq;
    logic deq;

    assign notEmpty = (cnt != '0);
    assign inReady  = (cnt < CNT_W'(DEPTH));
    // Register 0 results complete the handshake but are dropped.
    assign enq      = inValid && inReady && (inReg != '0);
    assign deq      = regWrite;
    assign count    = cnt;

    assign regWrite  = notEmpty && drainEn;
    assign writeReg  = notEmpty ? regMem[rdPtr]  : '0;
    assign writeData = notEmpty ? dataMem[rdPtr] : '0;

    // Storage is not reset; occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (enq) begin
            regMem[wrPtr]  <= inReg;
            dataMem[wrPtr] <= inData;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdPtr <= '0;
            wrPtr <= '0;
            cnt   <= '0;
        end else begin
            if (enq) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (deq) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            unique case ({enq, deq})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    // Walk from oldest to youngest so the last match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        queryHit  = 1'b0;
        queryData = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rdPtr + PTR_W'(i);
            if ((CNT_W'(i) < cnt) && (queryReg != '0) &&
                (regMem[idx] == queryReg)) begin
                queryHit  = 1'b1;
                queryData = dataMem[idx];
            end
        end
    end
`else
    logic unusedQuery;
    assign unusedQuery = ^queryReg;
    assign queryHit    = 1'b0;
    assign queryData   = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed stimulus against a queue-based reference model.
// Forwarding expectations follow WB_FORWARD_EN.
module tb_writeback_queue;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              inValid;
    logic              inReady;
    logic [ADDR_W-1:0] inReg;
    logic [DATA_W-1:0] inData;
    logic              drainEn;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] queryReg;
    logic              queryHit;
    logic [DATA_W-1:0] queryData;
    logic [2:0]        count;

    int checks = 0;
    int failures = 0;
    int peak = 0;

    typedef logic [ADDR_W+DATA_W-1:0] ent_t;
    ent_t mq[$];
    ent_t wlog[$];

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .inValid(inValid), .inReady(inReady),
        .inReg(inReg), .inData(inData),
        .drainEn(drainEn),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .queryReg(queryReg), .queryHit(queryHit), .queryData(queryData),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: a FIFO of pending results plus a log of commits.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
        end else begin
            bit doDeq;
            bit doEnq;
            doDeq = (mq.size() != 0) && drainEn;
            doEnq = inValid && (mq.size() < DEPTH) && (inReg != 0);
            if (doDeq) begin
                wlog.push_back(mq[0]);
                void'(mq.pop_front());
            end
            if (doEnq) mq.push_back({inReg, inData});
        end
    end

    always @(negedge clk) begin
        logic [ADDR_W-1:0] eReg;
        logic [DATA_W-1:0] eData;
        logic              fHit;
        logic [DATA_W-1:0] fData;
        eReg  = '0;
        eData = '0;
        fHit  = 1'b0;
        fData = '0;
        if (mq.size() != 0) begin
            eReg  = mq[0][ADDR_W+DATA_W-1:DATA_W];
            eData = mq[0][DATA_W-1:0];
        end
`ifdef WB_FORWARD_EN
        if (queryReg != 0) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!fHit && mq[i][ADDR_W+DATA_W-1:DATA_W] == queryReg) begin
                    fHit  = 1'b1;
                    fData = mq[i][DATA_W-1:0];
                end
            end
        end
`endif
        chk("regWrite", 64'(regWrite), 64'((mq.size() != 0) && drainEn));
        chk("writeReg", 64'(writeReg), 64'(eReg));
        chk("writeData", writeData, eData);
        chk("inReady", 64'(inReady), 64'(mq.size() < DEPTH));
        chk("count", 64'(count), 64'(mq.size()));
        chk("queryHit", 64'(queryHit), 64'(fHit));
        chk("queryData", queryData, fData);
        if (int'(count) > peak) peak = int'(count);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drainAll();
        drainEn = 1'b1;
        inValid = 1'b0;
        for (int k = 0; k < 20 && count != 0; k++) tick();
        chk("drain_empty", 64'(count), 64'd0);
    endtask

    initial begin
        bit acc;
        int base;
        rst_n    = 1'b0;
        inValid  = 1'b0;
        inReg    = '0;
        inData   = '0;
        drainEn  = 1'b0;
        queryReg = '0;
        tick();
        tick();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_inReady", 64'(inReady), 64'd1);
        rst_n = 1'b1;
        tick();

        // Streaming two results with the write port open.
        peak    = 0;
        drainEn = 1'b1;
        inValid = 1'b1; inReg = 5'd3; inData = 64'hA;
        tick();
        inReg = 5'd4; inData = 64'hB;
        tick();
        inValid = 1'b0;
        repeat (3) tick();
        chk("stream_len", 64'(wlog.size()), 64'd2);
        if (wlog.size() == 2) begin
            chk("stream_w0", 64'(wlog[0]), 64'({5'd3, 64'hA}));
            chk("stream_w1", 64'(wlog[1]), 64'({5'd4, 64'hB}));
            chk("stream_w0_reg", 64'(wlog[0][68:64]), 64'd3);
        end
        chk("stream_peak", 64'(peak), 64'd1);

        // Fill to capacity, then release the write port.
        drainEn = 1'b0;
        base = wlog.size();
        for (int i = 0; i < 4; i++) begin
            inValid = 1'b1; inReg = ADDR_W'(8 + i); inData = 64'(256 + i);
            tick();
        end
        inReg = 5'd12; inData = 64'h104;
        tick();
        chk("full_count", 64'(count), 64'd4);
        chk("full_inReady", 64'(inReady), 64'd0);
        drainEn = 1'b1;
        tick();
        chk("full_ready_rise", 64'(inReady), 64'd1);
        acc = 1'b0;
        for (int k = 0; k < 10 && !acc; k++) begin
            if (inReady) acc = 1'b1;
            tick();
        end
        chk("full_fifth_acc", 64'(acc), 64'd1);
        drainAll();
        chk("full_len", 64'(wlog.size() - base), 64'd5);
        if (wlog.size() == base + 5) begin
            for (int i = 0; i < 5; i++)
                chk("full_order", 64'(wlog[base+i][68:64]), 64'(8 + i));
            chk("full_last_data", wlog[base+4][63:0], 64'h104);
        end

        // Register 0 results are dropped.
        drainEn = 1'b0;
        base = wlog.size();
        inValid = 1'b1; inReg = 5'd0; inData = 64'hFFFF;
        tick();
        inValid = 1'b0;
        tick();
        chk("r0_count", 64'(count), 64'd0);
        chk("r0_regWrite", 64'(regWrite), 64'd0);
        drainEn = 1'b1;
        tick();
        chk("r0_nolog", 64'(wlog.size() - base), 64'd0);

        // Enqueue and dequeue on the same edge at count 2.
        drainEn = 1'b0;
        base = wlog.size();
        inValid = 1'b1; inReg = 5'd1; inData = 64'h11;
        tick();
        inReg = 5'd2; inData = 64'h22;
        tick();
        chk("sim_pre", 64'(count), 64'd2);
        drainEn = 1'b1;
        inReg = 5'd5; inData = 64'h55;
        tick();
        chk("sim_count", 64'(count), 64'd2);
        drainAll();
        if (wlog.size() == base + 3) begin
            chk("sim_o0", 64'(wlog[base][68:64]), 64'd1);
            chk("sim_o1", 64'(wlog[base+1][68:64]), 64'd2);
            chk("sim_o2", 64'(wlog[base+2][68:64]), 64'd5);
        end else begin
            chk("sim_len", 64'(wlog.size() - base), 64'd3);
        end

        // Forwarding lookup with two writes to r7.
        drainEn = 1'b0;
        inValid = 1'b1; inReg = 5'd7; inData = 64'h1;
        tick();
        inData = 64'h2;
        tick();
        inValid = 1'b0;
        queryReg = 5'd7;
        #1;
`ifdef WB_FORWARD_EN
        chk("fwd_hit", 64'(queryHit), 64'd1);
        chk("fwd_data", queryData, 64'h2);
`else
        chk("fwd_hit", 64'(queryHit), 64'd0);
        chk("fwd_data", queryData, 64'h0);
`endif
        queryReg = 5'd0;
        #1;
        chk("fwd_r0", 64'(queryHit), 64'd0);
        tick();

        // Reset with three entries pending.
        inValid = 1'b1; inReg = 5'd9; inData = 64'h99;
        tick();
        inValid = 1'b0;
        chk("rst_pre", 64'(count), 64'd3);
        drainEn = 1'b1;
        base = wlog.size();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_count", 64'(count), 64'd0);
        chk("rst2_regWrite", 64'(regWrite), 64'd0);
        chk("rst2_writeReg", 64'(writeReg), 64'd0);
        chk("rst2_inReady", 64'(inReady), 64'd1);
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("rst2_nolog", 64'(wlog.size() - base), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
